// File: rtl/alu_cdb_arbiter_if.sv
// Bundle between the ALU result sources and the CDB arbiter.
// The master side drives ALU results and squash; the slave side is the arbiter.
interface alu_cdb_arbiter_if #(
  parameter int NUM_ALU = 4,
  parameter int NUM_CDB = 2,
  parameter int PACK_W  = 32
);
  localparam int SRC_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  logic [NUM_ALU-1:0]             alu_ready;
  logic [NUM_ALU-1:0][PACK_W-1:0] alu_pack;
  logic                           squash;
  logic [NUM_ALU-1:0]             alu_stall;
  logic                           busy;
  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB-1:0][PACK_W-1:0] cdb_pack;
  logic [NUM_CDB-1:0][SRC_W-1:0]  cdb_src;

  modport master (
    output alu_ready, alu_pack, squash,
    input  alu_stall, busy, cdb_valid, cdb_pack, cdb_src
  );

  modport slave (
    input  alu_ready, alu_pack, squash,
    output alu_stall, busy, cdb_valid, cdb_pack, cdb_src
  );
endinterface

// File: rtl/alu_cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_CDB ready ALU results per cycle onto CDB ports.
// Define ALU_CDB_ARB_PERF_EN to add perf_grants / perf_stall_cycles counters.
module alu_cdb_arbiter #(
  parameter int NUM_ALU = 4,
  parameter int NUM_CDB = 2,
  parameter int PACK_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  alu_cdb_arbiter_if.slave   bus
`ifdef ALU_CDB_ARB_PERF_EN
  ,
  output logic [31:0]        perf_grants,
  output logic [31:0]        perf_stall_cycles
`endif
);

  localparam int SRC_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  localparam int unsigned NA = NUM_ALU;
  localparam int unsigned NC = NUM_CDB;

  logic [SRC_W-1:0]               r_rr_ptr;
  logic [NUM_CDB-1:0]             r_cdb_valid;
  logic [NUM_CDB-1:0][PACK_W-1:0] r_cdb_pack;
  logic [NUM_CDB-1:0][SRC_W-1:0]  r_cdb_src;

  logic [NUM_ALU-1:0]             w_grant;
  logic [NUM_ALU-1:0]             w_stall;
  logic [NUM_CDB-1:0]             w_port_vld;
  logic [NUM_CDB-1:0][PACK_W-1:0] w_port_pack;
  logic [NUM_CDB-1:0][SRC_W-1:0]  w_port_src;
  logic [SRC_W-1:0]               w_next_ptr;
  logic                           w_any_grant;

  // Walk positions rr_ptr..rr_ptr+NUM_ALU-1 (mod NUM_ALU); the k-th hit goes to port k.
  always_comb begin : scan
    int unsigned v_cnt;
    int unsigned v_pos;
    logic [SRC_W-1:0] v_idx;
    w_grant     = '0;
    w_port_vld  = '0;
    w_port_pack = '0;
    w_port_src  = '0;
    w_next_ptr  = r_rr_ptr;
    w_any_grant = 1'b0;
    v_cnt       = 0;
    v_pos       = 0;
    v_idx       = '0;
    for (int unsigned j = 0; j < NA; j++) begin
      v_pos = 32'(r_rr_ptr) + j;
      if (v_pos >= NA) v_pos = v_pos - NA;
      v_idx = SRC_W'(v_pos);
      if (!bus.squash && bus.alu_ready[v_idx] && (v_cnt < NC)) begin
        w_grant[v_idx] = 1'b1;
        for (int unsigned k = 0; k < NC; k++) begin
          if (v_cnt == k) begin
            w_port_vld[k]  = 1'b1;
            w_port_src[k]  = v_idx;
            w_port_pack[k] = bus.alu_pack[v_idx];
          end
        end
        w_next_ptr  = (v_pos == NA - 1) ? '0 : SRC_W'(v_pos + 1);
        w_any_grant = 1'b1;
        v_cnt       = v_cnt + 1;
      end
    end
  end

  assign w_stall       = bus.squash ? '0 : (bus.alu_ready & ~w_grant);
  assign bus.alu_stall = w_stall;
  assign bus.busy      = |w_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      r_cdb_pack  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_port_vld;
      r_cdb_pack  <= w_port_pack;
      r_cdb_src   <= w_port_src;
      if (w_any_grant) r_rr_ptr <= w_next_ptr;
    end
  end

  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_pack  = r_cdb_pack;
  assign bus.cdb_src   = r_cdb_src;

`ifdef ALU_CDB_ARB_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stall_cycles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_grants       <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      r_perf_grants <= r_perf_grants + 32'($countones(w_grant));
      if (bus.busy) r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
    end
  end

  assign perf_grants       = r_perf_grants;
  assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_alu_cdb_arbiter.sv
// Directed bench for alu_cdb_arbiter with NUM_ALU=4, NUM_CDB=2.
// Expected values are hand-derived from the round-robin grant rules.
module tb_alu_cdb_arbiter;
  localparam int NA = 4;
  localparam int NC = 2;
  localparam int PW = 16;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_bad;

`ifdef ALU_CDB_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [31:0] perf_stall_cycles;
`endif

  alu_cdb_arbiter_if #(.NUM_ALU(NA), .NUM_CDB(NC), .PACK_W(PW)) bus ();

  alu_cdb_arbiter #(.NUM_ALU(NA), .NUM_CDB(NC), .PACK_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ALU_CDB_ARB_PERF_EN
    ,
    .perf_grants       (perf_grants),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    bus.alu_ready = r;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.squash = 1'b0;
    bus.alu_ready = '0;
    for (int i = 0; i < NA; i++) bus.alu_pack[i] = 16'(16'h1111 * (i + 1));

    #2;
    check("rst_valid", 32'(bus.cdb_valid), 32'h0);
    check("rst_src",   32'(bus.cdb_src),   32'h0);
    check("rst_pack",  32'(bus.cdb_pack),  32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    set_ready(4'b1111);
    check("rst_stall", 32'(bus.alu_stall), 32'b1100);
    tick();
    tick();
    check("rst_hold_valid", 32'(bus.cdb_valid), 32'h0);

    // Release reset, all ready: ports get 0,1 then 2,3
    reset = 1'b0;
    #1;
    check("c0_stall", 32'(bus.alu_stall), 32'b1100);
    check("c0_busy",  32'(bus.busy),      32'h1);
    tick();
    check("c1_valid", 32'(bus.cdb_valid), 32'b11);
    check("c1_src0",  32'(bus.cdb_src[0]), 32'd0);
    check("c1_src1",  32'(bus.cdb_src[1]), 32'd1);
    check("c1_pack0", 32'(bus.cdb_pack[0]), 32'h1111);
    check("c1_pack1", 32'(bus.cdb_pack[1]), 32'h2222);
    check("c1_stall", 32'(bus.alu_stall), 32'b0011);
    tick();
    check("c2_src0",  32'(bus.cdb_src[0]), 32'd2);
    check("c2_src1",  32'(bus.cdb_src[1]), 32'd3);
    check("c2_pack0", 32'(bus.cdb_pack[0]), 32'h3333);
    check("c2_pack1", 32'(bus.cdb_pack[1]), 32'h4444);
    check("c2_stall", 32'(bus.alu_stall), 32'b1100);

    // rr=0, only ALU2 ready -> rr becomes 3
    set_ready(4'b0100);
    check("a_stall", 32'(bus.alu_stall), 32'h0);
    tick();
    check("a_valid", 32'(bus.cdb_valid), 32'b01);
    check("a_src0",  32'(bus.cdb_src[0]), 32'd2);
    check("a_src1",  32'(bus.cdb_src[1]), 32'd0);
    check("a_pack1", 32'(bus.cdb_pack[1]), 32'h0);

    // rr=3, ready=1001 -> wrap: port0=3, port1=0, rr becomes 1
    set_ready(4'b1001);
    check("w_stall", 32'(bus.alu_stall), 32'h0);
    tick();
    check("w_valid", 32'(bus.cdb_valid), 32'b11);
    check("w_src0",  32'(bus.cdb_src[0]), 32'd3);
    check("w_src1",  32'(bus.cdb_src[1]), 32'd0);
    check("w_pack0", 32'(bus.cdb_pack[0]), 32'h4444);
    check("w_pack1", 32'(bus.cdb_pack[1]), 32'h1111);

    // rr=1, ready=0100 -> port0=2, rr becomes 3
    set_ready(4'b0100);
    tick();
    check("b_valid", 32'(bus.cdb_valid), 32'b01);
    check("b_src0",  32'(bus.cdb_src[0]), 32'd2);
    set_ready(4'b0000);
    check("idle_busy",  32'(bus.busy),      32'h0);
    check("idle_stall", 32'(bus.alu_stall), 32'h0);
    tick();
    check("idle_valid", 32'(bus.cdb_valid), 32'b00);
    check("idle_src",   32'(bus.cdb_src),   32'h0);
    check("idle_pack",  32'(bus.cdb_pack),  32'h0);

    // rr held at 3: grant 3,0 and stall 1,2
    set_ready(4'b1111);
    check("hold_stall", 32'(bus.alu_stall), 32'b0110);
    tick();
    check("hold_src0", 32'(bus.cdb_src[0]), 32'd3);
    check("hold_src1", 32'(bus.cdb_src[1]), 32'd0);

    // Squash with rr=1
    bus.squash = 1'b1;
    #1;
    check("sq_stall", 32'(bus.alu_stall), 32'h0);
    check("sq_busy",  32'(bus.busy),      32'h0);
    tick();
    check("sq_valid", 32'(bus.cdb_valid), 32'b00);
    check("sq_pack",  32'(bus.cdb_pack),  32'h0);
    bus.squash = 1'b0;
    #1;
    check("post_sq_stall", 32'(bus.alu_stall), 32'b1001);
    tick();
    check("post_sq_valid", 32'(bus.cdb_valid), 32'b11);
    check("post_sq_src0",  32'(bus.cdb_src[0]), 32'd1);
    check("post_sq_src1",  32'(bus.cdb_src[1]), 32'd2);

    // Reset pulsed between edges while broadcasting
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.cdb_valid), 32'b00);
    check("mid_rst_src",   32'(bus.cdb_src),   32'h0);
    check("mid_rst_pack",  32'(bus.cdb_pack),  32'h0);
    check("mid_rst_stall", 32'(bus.alu_stall), 32'b1100);
    #1;
    reset = 1'b0;
    set_ready(4'b0000);
    tick();
    check("after_rst_valid", 32'(bus.cdb_valid), 32'b00);
    set_ready(4'b1111);
    check("after_rst_stall", 32'(bus.alu_stall), 32'b1100);
    tick();
    check("after_rst_src0", 32'(bus.cdb_src[0]), 32'd0);
    check("after_rst_src1", 32'(bus.cdb_src[1]), 32'd1);

`ifdef ALU_CDB_ARB_PERF_EN
    set_ready(4'b0000);
    reset = 1'b1;
    #1;
    check("perf_rst_g", perf_grants,       32'd0);
    check("perf_rst_s", perf_stall_cycles, 32'd0);
    reset = 1'b0;
    set_ready(4'b1111);
    tick();
    tick();
    tick();
    set_ready(4'b0000);
    check("perf_grants", perf_grants,       32'd6);
    check("perf_stalls", perf_stall_cycles, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
